voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphony scheduler between the song event stream and a bank of `note_player` instances. Accepts note and wait events over a valid/ready handshake and assigns each note to a free voice. Wait events advance song time by a number of beats. Drives each voice's load interface and tracks voice occupancy from the voices' `done_with_note` flags.

## Interface
Parameters:
- NUM_VOICES, 3: number of `note_player` voices driven (1–8).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- play  in  1  high = run; low = pause (no accepts, wait counter frozen).
- beat  in  1  one-cycle 1/48 s tick.
- ev_valid  in  1  event present.
- ev_ready  out  1  event accepted on a cycle where ev_valid & ev_ready.
- ev_is_wait  in  1  1 = wait event, 0 = note event.
- ev_note  in  6  note number; 0 = rest.
- ev_duration  in  6  duration in beats.
- note_to_load  out  6*NUM_VOICES  voice i at bits [6i+5:6i]; held between loads.
- duration_to_load  out  6*NUM_VOICES  same packing as note_to_load.
- load_new_note  out  NUM_VOICES  one-cycle load pulse per voice.
- done_with_note  in  NUM_VOICES  from each voice's countdown timer.
- voice_busy  out  NUM_VOICES  internal occupancy bits.
- waiting  out  1  high while in S_WAIT.

## Operation
- FSM states:
  - S_RUN: accepts events.
  - S_WAIT: counts beats.
- Voice free when busy[i]==0.
- any_free = OR of ~busy.
- ev_ready = play & (state==S_RUN) & (any_free | STEAL). STEAL is 1 only when VOICE_STEAL_EN is defined. Readiness is independent of event type and data.
- Note event accepted, ev_note≠0:
  - target = lowest-index free voice.
  - If no voice is free, target = steal_ptr.
  - On the accept edge: note/duration fields of target ← event; load_new_note[target] ← 1 for one cycle; busy[target] ← 1; hold[target] ← 2.
- Note event with ev_note==0 (rest): accepted, no voice touched.
- Wait event accepted:
  - ev_duration==0: no-op, stay in S_RUN.
  - Otherwise: wait_cnt ← ev_duration, go to S_WAIT.
- S_WAIT:
  - On beat & play, wait_cnt decrements.
  - The decrement that reaches 0 returns the FSM to S_RUN on the same edge.
  - beat while play low is ignored.
- Busy tracking:
  - hold[i] (2-bit) decrements to 0 each cycle.
  - busy[i] clears on an edge where hold[i]==0 & done_with_note[i]==1.
  - hold masks the stale `done` from the previous note while the voice's timer reloads.
- Load and clear in the same cycle on one voice: load wins (busy stays 1, hold ← 2).
- Reset, including mid-wait or mid-load:
  - state ← S_RUN; wait_cnt, busy, hold, steal_ptr, load_new_note ← 0.
  - note_to_load and duration_to_load ← 0.
  - waiting ← 0.
  - ev_ready low during the reset cycle.

## Timing
- Accept at edge t. load_new_note and the new note/duration are visible in cycle t..t+1, one cycle after the handshake cycle.
- Back-to-back accepts are allowed every cycle. Allocation uses busy updated by the previous edge, so consecutive notes go to distinct voices.
- A voice is free again no earlier than 3 cycles after its load edge.
- Wait of D beats: ev_ready returns high on the cycle after the D-th counted beat.
- Outputs are all registered except ev_ready, which is combinational from state, busy, and play.

## Configuration
- VOICE_STEAL_EN defined:
  - With no voice free, a note event is still accepted and reloads voice steal_ptr.
  - steal_ptr then increments modulo NUM_VOICES.
  - Steals only; normal allocations do not move steal_ptr.
- VOICE_STEAL_EN undefined:
  - ev_ready stays low while all voices are busy; the event stalls until one frees.
  - No steal_ptr logic is synthesized.

## Test plan
- Reset: after reset high one cycle, all outputs are 0, voice_busy=000, ev_ready=1 with play=1.
- Three back-to-back note events (notes 10, 20, 30, duration 5) go to voices 0, 1, 2. load_new_note is 001, 010, 100 on consecutive cycles, and voice_busy ends at 111.
- Fourth note while all busy:
  - Without VOICE_STEAL_EN: ev_ready=0 until a done_with_note rises and hold has expired. The note is then loaded into that voice.
  - With VOICE_STEAL_EN: the note is accepted immediately into voice 0; a fifth steal goes to voice 1.
- Wait event with duration 3:
  - waiting=1 and ev_ready=0 for exactly three beats.
  - Dropping play mid-wait, with beats still pulsing, does not decrement.
  - ev_duration=0 returns immediately with no waiting pulse.
- Rest (note 0) and stale done:
  - The rest is accepted with no load pulse.
  - A done_with_note[0] held high through the load edge does not clear busy[0] within 2 cycles.
  - Reset asserted in S_WAIT returns waiting to 0 next cycle.

Source files
------------

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : Polyphony scheduler; hands each note event to a free
//               note_player voice and counts beats for wait events.
//               Optional voice stealing is enabled by defining VOICE_STEAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int NUM_VOICES = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      beat,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_is_wait,
    input  logic [5:0]                ev_note,
    input  logic [5:0]                ev_duration,
    output logic [6*NUM_VOICES-1:0]   note_to_load,
    output logic [6*NUM_VOICES-1:0]   duration_to_load,
    output logic [NUM_VOICES-1:0]     load_new_note,
    input  logic [NUM_VOICES-1:0]     done_with_note,
    output logic [NUM_VOICES-1:0]     voice_busy,
    output logic                      waiting
);

    localparam int       C_PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [5:0]            r_wait_cnt;
    logic [NUM_VOICES-1:0] r_busy;
    logic [NUM_VOICES-1:0] r_load;
    logic [1:0]            r_hold [NUM_VOICES];
    logic [5:0]            r_note [NUM_VOICES];
    logic [5:0]            r_dur  [NUM_VOICES];

    logic                  w_any_free;
    logic                  w_can_alloc;
    logic                  w_handshake;
    logic                  w_accept_note;
    logic                  w_accept_wait;
    logic                  w_start_wait;
    logic [C_PTR_W-1:0]    w_target;
    logic [NUM_VOICES-1:0] w_load_vec;

    assign w_any_free    = |(~r_busy);
    assign w_handshake   = ev_valid & ev_ready;
    assign w_accept_note = w_handshake & ~ev_is_wait & (ev_note != 6'd0);
    assign w_accept_wait = w_handshake & ev_is_wait;
    assign w_start_wait  = w_accept_wait & (ev_duration != 6'd0);

`ifdef VOICE_STEAL_EN
    logic [C_PTR_W-1:0] r_steal_ptr;

    assign w_can_alloc = 1'b1;

    // Only steals advance the pointer; normal allocations leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_steal_ptr <= '0;
        end else if (w_accept_note && !w_any_free) begin
            if (r_steal_ptr == C_PTR_W'(NUM_VOICES - 1))
                r_steal_ptr <= '0;
            else
                r_steal_ptr <= r_steal_ptr + C_PTR_W'(1);
        end
    end
`else
    assign w_can_alloc = w_any_free;
`endif

    // Lowest-index free voice wins; falls back to the steal pointer when full.
    always_comb begin
        w_target = '0;
`ifdef VOICE_STEAL_EN
        w_target = r_steal_ptr;
`endif
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!r_busy[i])
                w_target = C_PTR_W'(i);
        end
    end

    always_comb begin
        w_load_vec = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            w_load_vec[i] = w_accept_note && (w_target == C_PTR_W'(i));
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_RUN;
        else
            r_state <= w_state_next;
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (w_start_wait) w_state_next = S_WAIT;
            S_WAIT:  if (play && beat && r_wait_cnt == 6'd1) w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        waiting  = (r_state == S_WAIT);
        ev_ready = play & ~reset & (r_state == S_RUN) & w_can_alloc;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_wait_cnt <= 6'd0;
        else if (r_state == S_RUN && w_start_wait)
            r_wait_cnt <= ev_duration;
        else if (r_state == S_WAIT && play && beat)
            r_wait_cnt <= r_wait_cnt - 6'd1;
    end

    // hold masks the previous note's done flag while the voice timer reloads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            r_load <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_hold[i] <= 2'd0;
                r_note[i] <= 6'd0;
                r_dur[i]  <= 6'd0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_load[i] <= w_load_vec[i];
                if (w_load_vec[i]) begin
                    r_note[i] <= ev_note;
                    r_dur[i]  <= ev_duration;
                    r_busy[i] <= 1'b1;
                    r_hold[i] <= 2'd2;
                end else begin
                    if (r_hold[i] != 2'd0)
                        r_hold[i] <= r_hold[i] - 2'd1;
                    if (r_hold[i] == 2'd0 && done_with_note[i])
                        r_busy[i] <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
            assign note_to_load[6*g +: 6]     = r_note[g];
            assign duration_to_load[6*g +: 6] = r_dur[g];
        end
    endgenerate

    assign load_new_note = r_load;
    assign voice_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_allocator
// Description : Directed self-checking bench for voice_allocator (3 voices).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int NUM_VOICES = 3;

    logic        clk = 1'b0;
    logic        reset, play, beat, ev_valid, ev_is_wait;
    logic        ev_ready, waiting;
    logic [5:0]  ev_note, ev_duration;
    logic [17:0] note_to_load, duration_to_load;
    logic [2:0]  load_new_note, done_with_note, voice_busy;

    int checks = 0;
    int errors = 0;

    voice_allocator #(.NUM_VOICES(NUM_VOICES)) dut (
        .clk(clk), .reset(reset), .play(play), .beat(beat),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_is_wait(ev_is_wait),
        .ev_note(ev_note), .ev_duration(ev_duration),
        .note_to_load(note_to_load), .duration_to_load(duration_to_load),
        .load_new_note(load_new_note), .done_with_note(done_with_note),
        .voice_busy(voice_busy), .waiting(waiting)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; ev_valid = 1'b0; beat = 1'b0; done_with_note = 3'b000;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b1; beat = 1'b0; ev_valid = 1'b0;
        ev_is_wait = 1'b0; ev_note = 6'd0; ev_duration = 6'd0; done_with_note = 3'b000;
        #1;
        checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_during: got %b want 0", ev_ready); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ev_ready); end
        checks++; if (voice_busy !== 3'b000) begin errors++; $display("FAIL rst_busy: got %b want 000", voice_busy); end
        checks++; if (load_new_note !== 3'b000) begin errors++; $display("FAIL rst_load: got %b want 000", load_new_note); end
        checks++; if (note_to_load !== 18'd0 || duration_to_load !== 18'd0) begin errors++; $display("FAIL rst_fields: got %h/%h want 0/0", note_to_load, duration_to_load); end
        checks++; if (waiting !== 1'b0) begin errors++; $display("FAIL rst_waiting: got %b want 0", waiting); end
    endtask

    task automatic test_back_to_back();
        ev_valid = 1'b1; ev_is_wait = 1'b0; ev_duration = 6'd5; ev_note = 6'd10;
        step();
        checks++; if (load_new_note !== 3'b001) begin errors++; $display("FAIL b2b_load0: got %b want 001", load_new_note); end
        ev_note = 6'd20;
        step();
        checks++; if (load_new_note !== 3'b010) begin errors++; $display("FAIL b2b_load1: got %b want 010", load_new_note); end
        ev_note = 6'd30;
        step();
        checks++; if (load_new_note !== 3'b100) begin errors++; $display("FAIL b2b_load2: got %b want 100", load_new_note); end
        checks++; if (voice_busy !== 3'b111) begin errors++; $display("FAIL b2b_busy: got %b want 111", voice_busy); end
        checks++; if (note_to_load !== {6'd30, 6'd20, 6'd10}) begin errors++; $display("FAIL b2b_notes: got %h want %h", note_to_load, {6'd30, 6'd20, 6'd10}); end
        checks++; if (duration_to_load !== {6'd5, 6'd5, 6'd5}) begin errors++; $display("FAIL b2b_durs: got %h want %h", duration_to_load, {6'd5, 6'd5, 6'd5}); end
    endtask

    task automatic test_full();
        ev_note = 6'd40; ev_duration = 6'd9;
        #1;
`ifdef VOICE_STEAL_EN
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL steal_ready: got %b want 1", ev_ready); end
        step();
        checks++; if (load_new_note !== 3'b001) begin errors++; $display("FAIL steal0_load: got %b want 001", load_new_note); end
        checks++; if (note_to_load[5:0] !== 6'd40) begin errors++; $display("FAIL steal0_note: got %0d want 40", note_to_load[5:0]); end
        ev_note = 6'd50;
        step();
        checks++; if (load_new_note !== 3'b010) begin errors++; $display("FAIL steal1_load: got %b want 010", load_new_note); end
        checks++; if (note_to_load[11:6] !== 6'd50) begin errors++; $display("FAIL steal1_note: got %0d want 50", note_to_load[11:6]); end
        checks++; if (voice_busy !== 3'b111) begin errors++; $display("FAIL steal_busy: got %b want 111", voice_busy); end
`else
        checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL full_stall: got %b want 0", ev_ready); end
        done_with_note = 3'b010;
        step();
        checks++; if (ev_ready !== 1'b0 || voice_busy !== 3'b111) begin errors++; $display("FAIL full_hold: got ready=%b busy=%b want 0/111", ev_ready, voice_busy); end
        step();
        checks++; if (voice_busy !== 3'b101) begin errors++; $display("FAIL full_free: got %b want 101", voice_busy); end
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL full_ready: got %b want 1", ev_ready); end
        done_with_note = 3'b000;
        step();
        checks++; if (load_new_note !== 3'b010) begin errors++; $display("FAIL full_load: got %b want 010", load_new_note); end
        checks++; if (note_to_load[11:6] !== 6'd40 || duration_to_load[11:6] !== 6'd9) begin errors++; $display("FAIL full_fields: got %0d/%0d want 40/9", note_to_load[11:6], duration_to_load[11:6]); end
        checks++; if (voice_busy !== 3'b111) begin errors++; $display("FAIL full_busy: got %b want 111", voice_busy); end
`endif
        ev_valid = 1'b0;
    endtask

    task automatic test_wait();
        ev_valid = 1'b1; ev_is_wait = 1'b1; ev_duration = 6'd3; ev_note = 6'd0;
        step();
        ev_valid = 1'b0;
        checks++; if (waiting !== 1'b1 || ev_ready !== 1'b0) begin errors++; $display("FAIL wait_enter: got w=%b r=%b want 1/0", waiting, ev_ready); end
        beat = 1'b1; step(); beat = 1'b0; step();
        checks++; if (waiting !== 1'b1) begin errors++; $display("FAIL wait_beat1: got %b want 1", waiting); end
        play = 1'b0; beat = 1'b1;
        step(); step(); step();
        checks++; if (waiting !== 1'b1) begin errors++; $display("FAIL wait_paused: got %b want 1", waiting); end
        play = 1'b1;
        step();
        checks++; if (waiting !== 1'b1 || ev_ready !== 1'b0) begin errors++; $display("FAIL wait_beat2: got w=%b r=%b want 1/0", waiting, ev_ready); end
        step();
        beat = 1'b0;
        #1;
        checks++; if (waiting !== 1'b0 || ev_ready !== 1'b1) begin errors++; $display("FAIL wait_done: got w=%b r=%b want 0/1", waiting, ev_ready); end
        ev_valid = 1'b1; ev_duration = 6'd0;
        step();
        ev_valid = 1'b0;
        checks++; if (waiting !== 1'b0 || ev_ready !== 1'b1) begin errors++; $display("FAIL wait_zero: got w=%b r=%b want 0/1", waiting, ev_ready); end
    endtask

    task automatic test_rest_stale();
        ev_valid = 1'b1; ev_is_wait = 1'b0; ev_note = 6'd0; ev_duration = 6'd7;
        step();
        checks++; if (load_new_note !== 3'b000 || voice_busy !== 3'b000) begin errors++; $display("FAIL rest: got load=%b busy=%b want 000/000", load_new_note, voice_busy); end
        done_with_note = 3'b001; ev_note = 6'd12; ev_duration = 6'd4;
        step();
        ev_valid = 1'b0;
        checks++; if (load_new_note !== 3'b001 || voice_busy !== 3'b001) begin errors++; $display("FAIL stale_load: got load=%b busy=%b want 001/001", load_new_note, voice_busy); end
        step();
        checks++; if (voice_busy !== 3'b001) begin errors++; $display("FAIL stale_c1: got %b want 001", voice_busy); end
        step();
        checks++; if (voice_busy !== 3'b001) begin errors++; $display("FAIL stale_c2: got %b want 001", voice_busy); end
        step();
        checks++; if (voice_busy !== 3'b000) begin errors++; $display("FAIL stale_c3: got %b want 000", voice_busy); end
        done_with_note = 3'b000;
    endtask

    task automatic test_reset_in_wait();
        ev_valid = 1'b1; ev_is_wait = 1'b1; ev_duration = 6'd5;
        step();
        ev_valid = 1'b0;
        checks++; if (waiting !== 1'b1) begin errors++; $display("FAIL rw_enter: got %b want 1", waiting); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (waiting !== 1'b0) begin errors++; $display("FAIL rw_waiting: got %b want 0", waiting); end
        #1;
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL rw_ready: got %b want 1", ev_ready); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full();
        do_reset();
        test_wait();
        test_rest_stale();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
